// File: rtl/decode_stage_pipe.sv
// Registered RV32I decode stage with valid/ready input, 1-entry skid buffer, stall hold and jump flush.
// Optional M-extension decode of OP/funct7=0000001 is enabled by defining MULDIV_EN.
module decode_stage_pipe #(
  parameter int XLEN            = 32,
  parameter bit ZERO_RD_INVALID = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            jmp,
  input  logic            stall,
  output logic            out_valid,
  output logic [5:0]      func,
  output logic [1:0]      variant,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            rs1v,
  output logic            rs2v,
  output logic            rdv,
  output logic [XLEN-1:0] left,
  output logic [XLEN-1:0] right,
  output logic [XLEN-1:0] extra,
  output logic [XLEN-1:0] out_addr
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] CL_ALUR  = 3'd0;
  localparam logic [2:0] CL_ALUI  = 3'd1;
  localparam logic [2:0] CL_LOAD  = 3'd2;
  localparam logic [2:0] CL_STORE = 3'd3;
  localparam logic [2:0] CL_BR    = 3'd4;
  localparam logic [2:0] CL_JMP   = 3'd5;
  localparam logic [2:0] CL_UPPER = 3'd6;
  localparam logic [2:0] CL_MISC  = 3'd7;

  localparam logic [1:0] V_NORM = 2'd0;
  localparam logic [1:0] V_ALT  = 2'd1;
  localparam logic [1:0] V_MUL  = 2'd2;

  typedef struct packed {
    logic [5:0]      func;
    logic [1:0]      variant;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1v;
    logic            rs2v;
    logic            rdv;
    logic [XLEN-1:0] left;
    logic [XLEN-1:0] right;
    logic [XLEN-1:0] extra;
    logic [XLEN-1:0] pc;
  } bundle_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic bundle_t decode(input logic [31:0]     i,
                                     input logic [XLEN-1:0] pc,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    bundle_t                d;
    logic                   ill;
    logic [6:0]             op;
    logic [2:0]             f3;
    logic [6:0]             f7;
    logic signed [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0]        link;
    op    = i[6:0];
    f3    = i[14:12];
    f7    = i[31:25];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_s = {{20{i[31]}}, i[31:25], i[11:7]};
    imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    imm_u = {i[31:12], 12'b0};
    imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    link  = pc + XLEN'(4);
    d     = '0;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    d.pc  = pc;
    ill   = 1'b0;
    case (op)
      OP_REG: begin
        d.func = {CL_ALUR, f3};
        d.rs1v = 1'b1; d.rs2v = 1'b1; d.rdv = 1'b1;
        d.left = a;    d.right = b;
        if (f7 == 7'b0000000)
          d.variant = V_NORM;
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          d.variant = V_ALT;
`ifdef MULDIV_EN
        else if (f7 == 7'b0000001)
          d.variant = V_MUL;
`endif
        else
          ill = 1'b1;
      end
      OP_IMM: begin
        d.func  = {CL_ALUI, f3};
        d.rs1v  = 1'b1; d.rdv = 1'b1;
        d.left  = a;
        d.right = sext32(imm_i);
        // shift-immediates reuse the upper imm bits as funct7
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      d.variant = V_ALT;
          else if (f7 != 7'b0000000) ill = 1'b1;
        end
      end
      OP_LOAD: begin
        d.func  = {CL_LOAD, f3};
        d.rs1v  = 1'b1; d.rdv = 1'b1;
        d.left  = a;
        d.right = sext32(imm_i);
        ill     = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        d.func  = {CL_STORE, f3};
        d.rs1v  = 1'b1; d.rs2v = 1'b1;
        d.left  = a;
        d.right = sext32(imm_s);
        d.extra = b;
        ill     = f3[2] || (f3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        d.func  = {CL_BR, f3};
        d.rs1v  = 1'b1; d.rs2v = 1'b1;
        d.left  = a;    d.right = b;
        d.extra = sext32(imm_b);
        ill     = (f3[2:1] == 2'b01);
      end
      OP_JAL: begin
        d.func  = {CL_JMP, 3'd0};
        d.rdv   = 1'b1;
        d.left  = pc;
        d.right = sext32(imm_j);
        d.extra = link;
      end
      OP_JALR: begin
        d.func  = {CL_JMP, 3'd1};
        d.rs1v  = 1'b1; d.rdv = 1'b1;
        d.left  = a;
        d.right = sext32(imm_i);
        d.extra = link;
        ill     = (f3 != 3'b000);
      end
      OP_LUI: begin
        d.func  = {CL_UPPER, 3'd0};
        d.rdv   = 1'b1;
        d.right = sext32(imm_u);
      end
      OP_AUIPC: begin
        d.func  = {CL_UPPER, 3'd1};
        d.rdv   = 1'b1;
        d.left  = pc;
        d.right = sext32(imm_u);
      end
      OP_SYSTEM, OP_FENCE: d.func = {CL_MISC, 3'd1};
      default:             ill = 1'b1;
    endcase
    if (ill) begin
      d.func    = {CL_MISC, 3'd0};
      d.variant = V_NORM;
      d.rs1v    = 1'b0; d.rs2v  = 1'b0; d.rdv   = 1'b0;
      d.left    = '0;   d.right = '0;   d.extra = '0;
    end
    if (ZERO_RD_INVALID && d.rd == 5'd0)
      d.rdv = 1'b0;
    return d;
  endfunction

  bundle_t dec_p0;
  bundle_t skid_p1;
  bundle_t out_p1;
  logic    vld_p1;
  logic    skid_vld_p1;
  logic    accept;
  logic    capture;

  // Stage 0: decode the incoming instruction with the operands read this cycle
  assign in_ready = !skid_vld_p1 && !rst;
  assign accept   = in_valid && in_ready;
  assign capture  = accept && vld_p1 && stall && !jmp;
  assign dec_p0   = decode(inst, addr, dataA, dataB);

  // Stage 1: output register and skid entry
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_p1      <= '0;
    end else if (jmp) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1 || !stall) begin
      if (skid_vld_p1) begin
        out_p1      <= skid_p1;
        vld_p1      <= 1'b1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        out_p1 <= dec_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture)
      skid_p1 <= dec_p0;
  end

  assign out_valid = vld_p1;
  assign func      = out_p1.func;
  assign variant   = out_p1.variant;
  assign rs1       = out_p1.rs1;
  assign rs2       = out_p1.rs2;
  assign rd        = out_p1.rd;
  assign rs1v      = out_p1.rs1v;
  assign rs2v      = out_p1.rs2v;
  assign rdv       = out_p1.rdv;
  assign left      = out_p1.left;
  assign right     = out_p1.right;
  assign extra     = out_p1.extra;
  assign out_addr  = out_p1.pc;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: table of hand-decoded vectors streamed through a scoreboard,
// plus stall/skid, flush and mid-operation reset sequences.
module tb_decode_stage_pipe;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, jmp, stall, out_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] addr, dataA, dataB;
  logic [5:0]      func;
  logic [1:0]      variant;
  logic [4:0]      rs1, rs2, rd;
  logic            rs1v, rs2v, rdv;
  logic [XLEN-1:0] left, right, extra, out_addr;

  decode_stage_pipe #(.XLEN(XLEN), .ZERO_RD_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .addr(addr), .dataA(dataA), .dataB(dataB),
    .jmp(jmp), .stall(stall), .out_valid(out_valid),
    .func(func), .variant(variant), .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1v(rs1v), .rs2v(rs2v), .rdv(rdv),
    .left(left), .right(right), .extra(extra), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, addr, a, b;
    logic [5:0]  func;
    logic [1:0]  variant;
    logic [2:0]  v;
    logic [31:0] left, right, extra;
  } vec_t;

  localparam int N = 19;
  vec_t tab[N];
  vec_t sb[$];
  vec_t idle;
  int   nchecks = 0;
  int   nerr    = 0;

  function automatic vec_t mk(input logic [31:0] i, ad, a, b, input logic [5:0] f,
                              input logic [1:0] va, input logic [2:0] v,
                              input logic [31:0] l, r, x);
    vec_t e;
    e.inst = i; e.addr = ad; e.a = a; e.b = b; e.func = f; e.variant = va;
    e.v = v; e.left = l; e.right = r; e.extra = x;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic consume();
    vec_t e;
    if (sb.size() == 0) begin
      nchecks++; nerr++;
      $display("FAIL unexpected_bundle: got pc 0x%0h func 0x%0h expected none", out_addr, func);
    end else begin
      e = sb.pop_front();
      chk("out_addr", out_addr, e.addr);
      chk("func", func, e.func);
      chk("variant", variant, e.variant);
      chk("regs", {rs1, rs2, rd}, {e.inst[19:15], e.inst[24:20], e.inst[11:7]});
      chk("vflags", {rs1v, rs2v, rdv}, e.v);
      chk("left", left, e.left);
      chk("right", right, e.right);
      chk("extra", extra, e.extra);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called just after a falling edge; the values set here are seen at the next rising edge.
  task automatic apply(input logic v, input vec_t e, input logic st, input logic j, output logic acc);
    if (out_valid && !st && !j) consume();
    stall = st; jmp = j; in_valid = v;
    inst = e.inst; addr = e.addr; dataA = e.a; dataB = e.b;
    acc = v && in_ready && !j;
    if (acc) sb.push_back(e);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      apply(1'b0, idle, 1'b0, 1'b0, acc);
      tick();
    end
    chk("drain_empty", sb.size(), 0);
    chk("idle_vld", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   idx;
    idle    = mk(32'h0, 32'h0, 32'h0, 32'h0, 6'h00, 2'd0, 3'b000, 0, 0, 0);
    tab[0]  = mk(32'h002081B3, 32'h10,  5,       7,    6'h00, 2'd0, 3'b111, 5, 7, 0);
    tab[1]  = mk(32'hFFF00293, 32'h14,  0,       32'h55, 6'h08, 2'd0, 3'b101, 0, 32'hFFFFFFFF, 0);
    tab[2]  = mk(32'h0020A423, 32'h18,  32'h1000, 32'hAB, 6'h1A, 2'd0, 3'b110, 32'h1000, 8, 32'hAB);
    tab[3]  = mk(32'h010000EF, 32'h100, 32'h77,  32'h88, 6'h28, 2'd0, 3'b001, 32'h100, 16, 32'h104);
    tab[4]  = mk(32'h40208233, 32'h20,  9,       4,    6'h00, 2'd1, 3'b111, 9, 4, 0);
    tab[5]  = mk(32'h0033D313, 32'h24,  32'hF0, 1,    6'h0D, 2'd0, 3'b101, 32'hF0, 3, 0);
    tab[6]  = mk(32'hFFC4A403, 32'h28,  32'h2000, 3,   6'h12, 2'd0, 3'b101, 32'h2000, 32'hFFFFFFFC, 0);
    tab[7]  = mk(32'hFE208CE3, 32'h2C,  1,       2,    6'h20, 2'd0, 3'b110, 1, 2, 32'hFFFFFFF8);
    tab[8]  = mk(32'h004280E7, 32'h30,  32'h400, 9,    6'h29, 2'd0, 3'b101, 32'h400, 4, 32'h34);
    tab[9]  = mk(32'h123453B7, 32'h34,  1,       2,    6'h30, 2'd0, 3'b001, 0, 32'h12345000, 0);
    tab[10] = mk(32'h80000397, 32'h38,  1,       2,    6'h31, 2'd0, 3'b001, 32'h38, 32'h80000000, 0);
    tab[11] = mk(32'h00208033, 32'h3C,  3,       4,    6'h00, 2'd0, 3'b110, 3, 4, 0);
    tab[12] = mk(32'h00000073, 32'h40,  5,       6,    6'h39, 2'd0, 3'b000, 0, 0, 0);
    tab[13] = mk(32'hFFFFFFFF, 32'h44,  5,       6,    6'h38, 2'd0, 3'b000, 0, 0, 0);
    tab[14] = mk(32'h00003003, 32'h48,  5,       6,    6'h38, 2'd0, 3'b000, 0, 0, 0);
    tab[15] = mk(32'h00002063, 32'h4C,  5,       6,    6'h38, 2'd0, 3'b000, 0, 0, 0);
    tab[16] = mk(32'h402091B3, 32'h50,  5,       6,    6'h38, 2'd0, 3'b000, 0, 0, 0);
`ifdef MULDIV_EN
    tab[17] = mk(32'h022081B3, 32'h54,  6,       7,    6'h00, 2'd2, 3'b111, 6, 7, 0);
`else
    tab[17] = mk(32'h022081B3, 32'h54,  6,       7,    6'h38, 2'd0, 3'b000, 0, 0, 0);
`endif
    tab[18] = mk(32'h0000000F, 32'h58,  5,       6,    6'h39, 2'd0, 3'b000, 0, 0, 0);

    rst = 1'b1; stall = 1'b0; jmp = 1'b0; in_valid = 1'b1;
    inst = tab[0].inst; addr = tab[0].addr; dataA = tab[0].a; dataB = tab[0].b;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_func", func, 6'h00);
    chk("rst_left", left, 0);
    chk("rst_flags", {rs1v, rs2v, rdv}, 3'b000);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", in_ready, 1'b1);

    // Back-to-back stream, no stall
    apply(1'b1, tab[0], 1'b0, 1'b0, acc);
    tick();
    chk("latency_out_valid", out_valid, 1'b1);
    for (int i = 1; i < N; i++) begin
      apply(1'b1, tab[i], 1'b0, 1'b0, acc);
      chk("stream_accept", acc, 1'b1);
      tick();
    end
    drain();

    // Stall for three cycles while two inputs are offered
    apply(1'b1, tab[0], 1'b0, 1'b0, acc); tick();
    apply(1'b1, tab[1], 1'b1, 1'b0, acc);
    chk("skid_accept", acc, 1'b1);
    tick();
    chk("skid_in_ready", in_ready, 1'b0);
    chk("stall_hold_vld", out_valid, 1'b1);
    chk("stall_hold_addr", out_addr, tab[0].addr);
    apply(1'b1, tab[2], 1'b1, 1'b0, acc);
    chk("skid_block", acc, 1'b0);
    tick();
    chk("stall_hold_addr2", out_addr, tab[0].addr);
    apply(1'b1, tab[2], 1'b1, 1'b0, acc); tick();
    apply(1'b1, tab[2], 1'b0, 1'b0, acc);
    chk("release_block", acc, 1'b0);
    tick();
    chk("drain_in_ready", in_ready, 1'b1);
    chk("drain_skid_addr", out_addr, tab[1].addr);
    apply(1'b1, tab[2], 1'b0, 1'b0, acc);
    chk("post_drain_accept", acc, 1'b1);
    tick();
    drain();

    // Flush with output and skid full, then flush of an accepted input
    apply(1'b1, tab[3], 1'b0, 1'b0, acc); tick();
    apply(1'b1, tab[4], 1'b1, 1'b0, acc); tick();
    chk("pre_flush_ready", in_ready, 1'b0);
    chk("pre_flush_vld", out_valid, 1'b1);
    apply(1'b1, tab[5], 1'b1, 1'b1, acc); tick();
    sb.delete();
    chk("flush_vld", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    apply(1'b1, tab[6], 1'b0, 1'b1, acc); tick();
    chk("flush_drop_vld", out_valid, 1'b0);
    apply(1'b1, tab[7], 1'b0, 1'b0, acc); tick();
    drain();

    // Random stall pattern over the whole table
    idx = 0;
    for (int k = 0; k < 400 && idx < N; k++) begin
      apply(1'b1, tab[idx], 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) idx++;
      tick();
    end
    chk("rand_all_sent", idx, N);
    drain();

    // Reset while output and skid hold bundles
    apply(1'b1, tab[8], 1'b0, 1'b0, acc); tick();
    apply(1'b1, tab[9], 1'b1, 1'b0, acc); tick();
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0;
    sb.delete();
    tick(); tick();
    chk("midrst_vld", out_valid, 1'b0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_right", right, 0);
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", in_ready, 1'b1);
    tick();
    chk("midrst_no_skid", out_valid, 1'b0);
    apply(1'b1, tab[10], 1'b0, 1'b0, acc); tick();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised, registered RV32I decode stage with a valid/ready input handshake, a 1-entry skid buffer, downstream stall hold and jump flush.
- Sits between the fetch stage and execute. Decodes `inst`, selects operands from register-file read data `dataA`/`dataB`, PC (`addr`) and immediates, and presents one decoded bundle per cycle.
- Successor to the fixed-width combinational decoder: adds XLEN generalisation, a pipeline register, flow control and optional M-extension decode.

Parameters:
- XLEN, 32, width of `addr`/`dataA`/`dataB`/`left`/`right`/`extra`. Immediates are sign-extended to XLEN. Only RV32I opcodes are decoded at any XLEN.
- ZERO_RD_INVALID, 1, when 1 `rdv` is forced to 0 for rd = x0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  fetch presents inst/addr
- in_ready  out  1  stage can accept; equals !skid_valid && !rst
- inst  in  32  instruction word
- addr  in  XLEN  PC of inst
- dataA  in  XLEN  regfile read data for inst[19:15], same cycle
- dataB  in  XLEN  regfile read data for inst[24:20], same cycle
- jmp  in  1  flush: discard everything held or accepted this cycle
- stall  in  1  downstream not ready; hold output bundle
- out_valid  out  1  decoded bundle valid
- func  out  6  {class[2:0], sub[2:0]}
- variant  out  2  0 normal, 1 alternate (funct7[5]: SUB/SRA/SRAI), 2 M-extension
- rs1, rs2, rd  out  5 each  register indices
- rs1v, rs2v, rdv  out  1 each  index is used
- left, right, extra  out  XLEN each  operands
- out_addr  out  XLEN  PC of bundle

Behaviour:
- Class encoding:
  - 0 ALU-reg: sub=funct3
  - 1 ALU-imm: sub=funct3
  - 2 LOAD: sub=funct3
  - 3 STORE: sub=funct3
  - 4 BRANCH: sub=funct3
  - 5 JAL (sub 0) / JALR (sub 1)
  - 6 LUI (sub 0) / AUIPC (sub 1)
  - 7 ILLEGAL (sub 0) / SYSTEM+FENCE (sub 1)
- Illegal covers: unknown opcode, bad funct7, undefined funct3.
- Operands:
  - ALU-reg and BRANCH: left=dataA, right=dataB.
  - ALU-imm, LOAD, STORE, JALR: left=dataA, right=imm.
  - STORE: extra=dataB. BRANCH: extra=imm. JAL/JALR: extra=addr+4.
  - JAL and AUIPC: left=addr, right=imm.
  - LUI: left=0, right=imm.
  - Class 7: left=right=extra=0, rs1v=rs2v=rdv=0.
  - All other cases: extra=0.
- Valid flags: rs1v/rs2v/rdv are 1 exactly when the format uses that field. rs1/rs2/rd are always the raw fields.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- Output register update:
  - Loads a new bundle when !out_valid || !stall.
  - Source is the skid entry if skid_valid, else the accepted input, else out_valid←0.
- Skid capture: if stall && out_valid and an input is accepted, the input is decoded into the skid entry. in_ready drops the next cycle.
- Skid drain: when stall deasserts, the skid entry moves to the output register and in_ready returns next cycle. An input accepted in that same cycle is impossible because in_ready=0.
- Decode timing: operand values are captured at accept time. No bypassing; hazards are handled elsewhere.
- Flush: jmp=1 clears out_valid and skid_valid next cycle and drops any input accepted that cycle. jmp has priority over stall and over all updates.
- Reset: out_valid=0, skid_valid=0, all bundle outputs 0, in_ready=0 while rst=1. in_ready=1 the first cycle after rst falls. Reset mid-operation discards all held bundles.

Optional Feature:
- Macro MULDIV_EN.
- Defined: OP opcode with funct7=0000001 decodes as class 0, sub=funct3, variant=2, with operands as ALU-reg.
- Undefined: that encoding decodes as ILLEGAL (func=0x38, variant=0, flags 0).

Test Plan:
- Reset then ADD x3,x1,x2 (0x002081B3), dataA=5, dataB=7 -> next cycle out_valid=1, func=0x00, variant=0, rs1=1, rs2=2, rd=3, all v=1, left=5, right=7.
- ADDI x5,x0,-1 (0xFFF00293) then SW x2,8(x1) (0x0020A423), dataB=0xAB:
  - ADDI -> func=0x08, right=0xFFFFFFFF, rs2v=0.
  - SW -> func=0x1A, right=8, extra=0xAB, rdv=0.
- JAL x1,16 (0x010000EF), addr=0x100 -> func=0x28, left=0x100, right=16, extra=0x104, rs1v=0.
- Stall held 3 cycles while 2 inputs are offered:
  - First input is captured to skid, in_ready=0.
  - On stall release the bundles appear in order, with no loss or duplication.
- jmp with out_valid=1, skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped inputs never appear.
- MUL x3,x1,x2 (0x022081B3) -> with MULDIV_EN: func=0x00, variant=2. Without: func=0x38, rdv=0.
